// File: rtl/roi_stats_if.sv
// Pixel stream, locked rectangle and statistics results shared by roi_stats and its driver.
// ROI_LUMA_EN adds the avg_Y result signal.
interface roi_stats_if #(
    parameter int CNT_W = 19
);
    logic              pix_en;
    logic [7:0]        raw_VGA_R;
    logic [7:0]        raw_VGA_G;
    logic [7:0]        raw_VGA_B;
    logic [12:0]       col;
    logic [12:0]       row;
    logic              roi_valid;
    logic [12:0]       roi_min_row;
    logic [12:0]       roi_max_row;
    logic [12:0]       roi_min_col;
    logic [12:0]       roi_max_col;
    logic [7:0]        avg_R;
    logic [7:0]        avg_G;
    logic [7:0]        avg_B;
    logic [CNT_W-1:0]  pix_count;
    logic              stats_valid;
    logic              busy;
`ifdef ROI_LUMA_EN
    logic [7:0]        avg_Y;
`endif

    modport master (
`ifdef ROI_LUMA_EN
        input  avg_Y,
`endif
        output pix_en, raw_VGA_R, raw_VGA_G, raw_VGA_B, col, row, roi_valid,
        output roi_min_row, roi_max_row, roi_min_col, roi_max_col,
        input  avg_R, avg_G, avg_B, pix_count, stats_valid, busy
    );

    modport slave (
`ifdef ROI_LUMA_EN
        output avg_Y,
`endif
        input  pix_en, raw_VGA_R, raw_VGA_G, raw_VGA_B, col, row, roi_valid,
        input  roi_min_row, roi_max_row, roi_min_col, roi_max_col,
        output avg_R, avg_G, avg_B, pix_count, stats_valid, busy
    );
endinterface

// File: rtl/roi_stats.sv
// Per-frame RGB average and pixel count over a locked inclusive rectangle, with a bit-serial divider.
// Optional macro ROI_LUMA_EN adds a registered luma (avg_Y) result.
module roi_stats #(
    parameter int H_LIMIT = 640,
    parameter int V_LIMIT = 480,
    parameter int SUM_W   = 27,
    parameter int CNT_W   = 19
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    roi_stats_if.slave  vid
);
    typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

    localparam logic [12:0]     LAST_ROW = 13'(V_LIMIT - 1);
    localparam logic [12:0]     LAST_COL = 13'(H_LIMIT - 1);
    localparam int              DC_W     = $clog2(SUM_W);
    localparam logic [DC_W-1:0] DIV_LAST = DC_W'(SUM_W - 1);

    state_t           r_state, w_state_next;
    logic             w_load, w_acc, w_div_start;

    logic [12:0]      r_sh_min_row, r_sh_max_row, r_sh_min_col, r_sh_max_col;
    logic [SUM_W-1:0] r_sum [3];
    logic [CNT_W-1:0] r_rem [3];
    logic [CNT_W-1:0] r_count;
    logic [DC_W-1:0]  r_div_cnt;
    logic [7:0]       r_avg [3];
    logic [CNT_W-1:0] r_pix_count;
    logic             r_stats_valid;

    logic             w_fs, w_fe, w_in_roi;
    logic [12:0]      w_min_row, w_max_row, w_min_col, w_max_col;
    logic [7:0]       w_pix [3];
    logic [CNT_W:0]   w_trial [3];
    logic             w_ge [3];
    logic [CNT_W-1:0] w_rem_next [3];
    logic [7:0]       w_q [3];

    assign w_fs = vid.pix_en && (vid.row == 13'd0) && (vid.col == 13'd0);
    assign w_fe = vid.pix_en && (vid.row == LAST_ROW) && (vid.col == LAST_COL);

    // The frame-start pixel is judged against the live bounds it is latching.
    assign w_min_row = w_fs ? vid.roi_min_row : r_sh_min_row;
    assign w_max_row = w_fs ? vid.roi_max_row : r_sh_max_row;
    assign w_min_col = w_fs ? vid.roi_min_col : r_sh_min_col;
    assign w_max_col = w_fs ? vid.roi_max_col : r_sh_max_col;
    assign w_in_roi  = vid.pix_en
                     && (vid.row >= w_min_row) && (vid.row <= w_max_row)
                     && (vid.col >= w_min_col) && (vid.col <= w_max_col);

    assign w_pix[0] = vid.raw_VGA_R;
    assign w_pix[1] = vid.raw_VGA_G;
    assign w_pix[2] = vid.raw_VGA_B;

    // Restoring step: the sum register shifts its dividend MSB out and the quotient bit in.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            w_trial[ch]    = {r_rem[ch], r_sum[ch][SUM_W-1]};
            w_ge[ch]       = (w_trial[ch] >= {1'b0, r_count});
            w_rem_next[ch] = w_ge[ch] ? (w_trial[ch][CNT_W-1:0] - r_count)
                                      : w_trial[ch][CNT_W-1:0];
            w_q[ch]        = (r_count == '0) ? 8'd0 : r_sum[ch][7:0];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_acc        = 1'b0;
        w_div_start  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fs && vid.roi_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (!vid.roi_valid) begin
                    w_state_next = IDLE;
                end else if (w_fs) begin
                    w_load = 1'b1;
                end else begin
                    w_acc = 1'b1;
                    if (w_fe) begin
                        w_div_start  = 1'b1;
                        w_state_next = DIV;
                    end
                end
            end
            DIV:     if (r_div_cnt == DIV_LAST) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: the small per-channel arrays are reset like any other register; a mid-frame reset must clear them.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sh_min_row  <= '0;
            r_sh_max_row  <= '0;
            r_sh_min_col  <= '0;
            r_sh_max_col  <= '0;
            r_count       <= '0;
            r_div_cnt     <= '0;
            r_pix_count   <= '0;
            r_stats_valid <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                r_sum[ch] <= '0;
                r_rem[ch] <= '0;
                r_avg[ch] <= '0;
            end
        end else begin
            r_stats_valid <= 1'b0;
            if (w_load) begin
                r_sh_min_row <= vid.roi_min_row;
                r_sh_max_row <= vid.roi_max_row;
                r_sh_min_col <= vid.roi_min_col;
                r_sh_max_col <= vid.roi_max_col;
                r_count      <= w_in_roi ? CNT_W'(1) : '0;
                for (int ch = 0; ch < 3; ch++)
                    r_sum[ch] <= w_in_roi ? SUM_W'(w_pix[ch]) : '0;
            end else if (w_acc && w_in_roi) begin
                r_count <= r_count + CNT_W'(1);
                for (int ch = 0; ch < 3; ch++)
                    r_sum[ch] <= r_sum[ch] + SUM_W'(w_pix[ch]);
            end else if (r_state == DIV) begin
                r_div_cnt <= r_div_cnt + DC_W'(1);
                for (int ch = 0; ch < 3; ch++) begin
                    r_sum[ch] <= {r_sum[ch][SUM_W-2:0], w_ge[ch]};
                    r_rem[ch] <= w_rem_next[ch];
                end
            end
            if (w_div_start) begin
                r_div_cnt <= '0;
                for (int ch = 0; ch < 3; ch++) r_rem[ch] <= '0;
            end
            if (r_state == DONE) begin
                r_pix_count   <= r_count;
                r_stats_valid <= 1'b1;
                for (int ch = 0; ch < 3; ch++) r_avg[ch] <= w_q[ch];
            end
        end
    end

`ifdef ROI_LUMA_EN
    logic [15:0] w_luma;
    logic [7:0]  r_avg_Y;

    assign w_luma = (16'd77 * 16'(w_q[0]) + 16'd150 * 16'(w_q[1]) + 16'd29 * 16'(w_q[2])) >> 8;

    always_ff @(posedge CLOCK_50) begin
        if (reset)                 r_avg_Y <= '0;
        else if (r_state == DONE)  r_avg_Y <= w_luma[7:0];
    end

    assign vid.avg_Y = r_avg_Y;
`endif

    assign vid.avg_R       = r_avg[0];
    assign vid.avg_G       = r_avg[1];
    assign vid.avg_B       = r_avg[2];
    assign vid.pix_count   = r_pix_count;
    assign vid.stats_valid = r_stats_valid;
    assign vid.busy        = (r_state == ACCUM) || (r_state == DIV);
endmodule

// File: tb/tb_roi_stats.sv
// Self-checking bench for roi_stats on a reduced 40x30 raster; a frame-level model predicts
// sums, averages, pulse timing and busy, and literal expectations pin the model per scenario.
module tb_roi_stats;
    localparam int H  = 40;
    localparam int V  = 30;
    localparam int SW = 27;
    localparam int CW = 19;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    roi_stats_if #(.CNT_W(CW)) vif ();

    roi_stats #(.H_LIMIT(H), .V_LIMIT(V), .SUM_W(SW), .CNT_W(CW)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .vid      (vif)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit checking_on = 1'b0;

    // Model state: what the outputs must show, and when.
    int m_cur_r = 0, m_cur_g = 0, m_cur_b = 0, m_cur_cnt = 0, m_cur_y = 0;
    int m_pend_r = 0, m_pend_g = 0, m_pend_b = 0, m_pend_cnt = 0, m_pend_y = 0;
    int m_pulse_cyc = -1;
    int m_clear_cyc = -1;
    int m_busy_from = -1;
    int m_busy_to   = -2;
    int fe_edge = 0;
    int last_pulse_cyc = -1000;
    int n_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc == m_clear_cyc) begin
            m_cur_r = 0; m_cur_g = 0; m_cur_b = 0; m_cur_cnt = 0; m_cur_y = 0;
        end
        if (cyc == m_pulse_cyc) begin
            m_cur_r = m_pend_r; m_cur_g = m_pend_g; m_cur_b = m_pend_b;
            m_cur_cnt = m_pend_cnt; m_cur_y = m_pend_y;
        end
        if (vif.stats_valid === 1'b1) begin
            last_pulse_cyc = cyc;
            n_pulses++;
        end
        if (checking_on) begin
            check("stats_valid", 32'(vif.stats_valid), 32'(cyc == m_pulse_cyc));
            check("busy", 32'(vif.busy), 32'(cyc >= m_busy_from && cyc <= m_busy_to));
            check("avg_R", 32'(vif.avg_R), 32'(m_cur_r));
            check("avg_G", 32'(vif.avg_G), 32'(m_cur_g));
            check("avg_B", 32'(vif.avg_B), 32'(m_cur_b));
            check("pix_count", 32'(vif.pix_count), 32'(m_cur_cnt));
`ifdef ROI_LUMA_EN
            check("avg_Y", 32'(vif.avg_Y), 32'(m_cur_y));
`endif
        end
    end

    function automatic logic [7:0] pv(input int mode, input int ch, input int r, input int c);
        logic [31:0] cv;
        cv = 32'(c);
        case (mode)
            0:       return (ch == 0) ? 8'd100 : (ch == 1) ? 8'd50 : 8'd200;
            1:       return (ch == 0) ? cv[7:0] : 8'd0;
            2:       return 8'd255;
            default: return (r == 5 && c == 7) ? 8'h3C : 8'd0;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vif.pix_en = 1'b0;
            rst        = 1'b0;
        end
    endtask

    // One raster frame plus a pix_en=0 blanking sample per row; the model tracks it at frame level.
    task automatic send_frame(input int mode, input int r0, input int r1, input int c0, input int c1,
                              input bit rv, input int abort_row, input int rst_row);
        bit acc = 1'b0;
        int sr = 0, sg = 0, sb = 0, cnt = 0;
        int e;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                @(posedge clk); #1;
                e = cyc + 1;
                vif.pix_en    = 1'b1;
                vif.row       = 13'(r);
                vif.col       = 13'(c);
                vif.raw_VGA_R = pv(mode, 0, r, c);
                vif.raw_VGA_G = pv(mode, 1, r, c);
                vif.raw_VGA_B = pv(mode, 2, r, c);
                vif.roi_valid = rv && (r < abort_row);
                rst           = (r == rst_row && c == 0);
                if (r == 0 && c == 0) begin
                    vif.roi_min_row = 13'(r0); vif.roi_max_row = 13'(r1);
                    vif.roi_min_col = 13'(c0); vif.roi_max_col = 13'(c1);
                end else begin
                    vif.roi_min_row = 13'd0;     vif.roi_max_row = 13'(V - 1);
                    vif.roi_min_col = 13'd0;     vif.roi_max_col = 13'(H - 1);
                end
                if (rst) begin
                    if (acc) m_busy_to = e - 1;
                    acc = 1'b0;
                    m_clear_cyc = e;
                end else if (acc && !vif.roi_valid) begin
                    acc = 1'b0;
                    m_busy_to = e - 1;
                end else if (!acc && r == 0 && c == 0 && vif.roi_valid) begin
                    acc = 1'b1;
                    sr = 0; sg = 0; sb = 0; cnt = 0;
                    m_busy_from = e;
                    m_busy_to   = 1 << 30;
                end
                if (acc && r >= r0 && r <= r1 && c >= c0 && c <= c1) begin
                    sr += int'(vif.raw_VGA_R);
                    sg += int'(vif.raw_VGA_G);
                    sb += int'(vif.raw_VGA_B);
                    cnt++;
                end
                if (acc && r == V - 1 && c == H - 1) begin
                    acc = 1'b0;
                    fe_edge    = e;
                    m_pend_r   = (cnt == 0) ? 0 : sr / cnt;
                    m_pend_g   = (cnt == 0) ? 0 : sg / cnt;
                    m_pend_b   = (cnt == 0) ? 0 : sb / cnt;
                    m_pend_cnt = cnt;
                    m_pend_y   = (77 * m_pend_r + 150 * m_pend_g + 29 * m_pend_b) >> 8;
                    m_pulse_cyc = e + SW + 1;
                    m_busy_to   = e + SW - 1;
                end
            end
            @(posedge clk); #1;
            vif.pix_en    = 1'b0;
            vif.row       = 13'(r0);
            vif.col       = 13'(c0);
            vif.raw_VGA_R = 8'd255;
            vif.raw_VGA_G = 8'd255;
            vif.raw_VGA_B = 8'd255;
            rst           = 1'b0;
        end
        idle(40);
    endtask

    task automatic lit(input string tag, input int r, input int g, input int b, input int n);
        check({tag, "_avg_R"}, 32'(vif.avg_R), 32'(r));
        check({tag, "_avg_G"}, 32'(vif.avg_G), 32'(g));
        check({tag, "_avg_B"}, 32'(vif.avg_B), 32'(b));
        check({tag, "_pix_count"}, 32'(vif.pix_count), 32'(n));
    endtask

    localparam int NONE = 1000;

    initial begin
        int p0;
        rst = 1'b1;
        vif.pix_en = 1'b0; vif.row = '0; vif.col = '0; vif.roi_valid = 1'b0;
        vif.raw_VGA_R = '0; vif.raw_VGA_G = '0; vif.raw_VGA_B = '0;
        vif.roi_min_row = '0; vif.roi_max_row = '0; vif.roi_min_col = '0; vif.roi_max_col = '0;
        repeat (3) @(posedge clk);
        #1;
        lit("reset", 0, 0, 0, 0);
        check("reset_stats_valid", 32'(vif.stats_valid), 32'd0);
        check("reset_busy", 32'(vif.busy), 32'd0);
        checking_on = 1'b1;
        rst = 1'b0;
        idle(5);

        // Uniform colour, 10x10 rectangle.
        send_frame(0, 10, 19, 20, 29, 1'b1, NONE, NONE);
        lit("uniform", 100, 50, 200, 100);
        check("uniform_latency", 32'(last_pulse_cyc - fe_edge), 32'd28);
`ifdef ROI_LUMA_EN
        check("uniform_avg_Y", 32'(vif.avg_Y), 32'd82);
`endif

        // Ramp on R across row 0, cols 0..9: 45/10 floors to 4.
        send_frame(1, 0, 0, 0, 9, 1'b1, NONE, NONE);
        lit("ramp", 4, 0, 0, 10);

        // Whole frame at full scale.
        send_frame(2, 0, V - 1, 0, H - 1, 1'b1, NONE, NONE);
        lit("full", 255, 255, 255, H * V);

        // Inverted column bounds: empty region still reports.
        p0 = n_pulses;
        send_frame(0, 10, 19, 9, 3, 1'b1, NONE, NONE);
        lit("empty", 0, 0, 0, 0);
        check("empty_pulsed", 32'(n_pulses - p0), 32'd1);

        // Single pixel at (5,7).
        send_frame(3, 5, 5, 7, 7, 1'b1, NONE, NONE);
        lit("single", 60, 60, 60, 1);

        // Not locked at frame start: nothing happens.
        p0 = n_pulses;
        send_frame(0, 10, 19, 20, 29, 1'b0, NONE, NONE);
        lit("unlocked", 60, 60, 60, 1);
        check("unlocked_no_pulse", 32'(n_pulses - p0), 32'd0);

        // Lock dropped mid-frame: abort.
        p0 = n_pulses;
        send_frame(0, 10, 19, 20, 29, 1'b1, 20, NONE);
        lit("abort", 60, 60, 60, 1);
        check("abort_no_pulse", 32'(n_pulses - p0), 32'd0);

        // Reset mid-accumulation clears outputs.
        p0 = n_pulses;
        send_frame(0, 10, 19, 20, 29, 1'b1, NONE, 15);
        lit("midreset", 0, 0, 0, 0);
        check("midreset_no_pulse", 32'(n_pulses - p0), 32'd0);

        // Next full frame after reset.
        send_frame(0, 10, 19, 20, 29, 1'b1, NONE, NONE);
        lit("recover", 100, 50, 200, 100);
        check("recover_latency", 32'(last_pulse_cyc - fe_edge), 32'd28);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
